// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join tracker: join semantics, FSM states and the job-ID width helper.
package fork_join_pkg;

  typedef enum logic [1:0] {
    JM_ALL  = 2'b00,
    JM_ANY  = 2'b01,
    JM_NONE = 2'b10
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    JOIN = 2'b10
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fj_lowest_bit_enc.sv
// Lowest-set-bit priority encoder; combinational, no backpressure.
module fj_lowest_bit_enc #(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fork_join_tracker.sv
// Fork/join tracker with ALL/ANY/NONE joins; the join is registered one edge after its condition and held until join_ready.
// Optional watchdog under JOIN_TIMEOUT_EN; fork_ready is low from accept until the join is consumed.
module fork_join_tracker
  import fork_join_pkg::*;
#(
  parameter int NUM_JOBS    = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fork_valid,
  output logic                        fork_ready,
  input  logic [NUM_JOBS-1:0]         fork_mask,
  input  logic [1:0]                  join_mode,
  input  logic [NUM_JOBS-1:0]         done_valid,
  output logic                        join_valid,
  input  logic                        join_ready,
  output logic [$clog2(NUM_JOBS)-1:0] join_first_id,
  output logic [CNT_W-1:0]            join_cycles,
  output logic                        join_timeout,
  output logic [NUM_JOBS-1:0]         active_mask,
  output logic                        busy
);

  localparam int JW = id_w(NUM_JOBS);

  if (NUM_JOBS < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("fork_join_tracker: NUM_JOBS must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_e              state;
  join_mode_e          mode;
  join_mode_e          mode_dec;
  logic [NUM_JOBS-1:0] wait_set;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [NUM_JOBS-1:0] active_next;
  logic [NUM_JOBS-1:0] hit;
  logic [JW-1:0]       hit_id;
  logic                hit_found;
  logic                accept;
  logic                join_cond;

  assign accept    = fork_valid && fork_ready;
  assign mode_dec  = (join_mode == JM_NONE) ? JM_NONE :
                     (join_mode == JM_ANY)  ? JM_ANY  : JM_ALL;
  // A done pulse retires the old instance before a same-edge fork re-arms the bit.
  assign active_next = (active_mask & ~done_valid) | (accept ? fork_mask : '0);
  assign hit         = done_valid & active_mask & wait_set;
  assign cnt_next    = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign join_cond   = (mode == JM_ANY) ? (|hit) : ((wait_set & active_next) == '0);
  assign busy        = (state != IDLE) || (|active_mask);

  fj_lowest_bit_enc #(.W(NUM_JOBS), .IW(JW)) u_enc (
    .vec   (hit),
    .idx   (hit_id),
    .found (hit_found)
  );

`ifdef JOIN_TIMEOUT_EN
  localparam logic [CNT_W:0] TO_LAST = (CNT_W + 1)'(TIMEOUT_CYC - 1);
  logic tmo;
  assign tmo = ({1'b0, cnt} == TO_LAST);
`else
  assign join_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mode          <= JM_ALL;
      wait_set      <= '0;
      cnt           <= '0;
      fork_ready    <= 1'b0;
      join_valid    <= 1'b0;
      join_first_id <= '0;
      join_cycles   <= '0;
      active_mask   <= '0;
`ifdef JOIN_TIMEOUT_EN
      join_timeout  <= 1'b0;
`endif
    end else begin
      active_mask <= active_next;
      case (state)
        IDLE: begin
          fork_ready <= !accept;
          if (accept) begin
            wait_set      <= fork_mask;
            mode          <= mode_dec;
            cnt           <= '0;
            join_cycles   <= '0;
            join_first_id <= '0;
`ifdef JOIN_TIMEOUT_EN
            join_timeout  <= 1'b0;
`endif
            if (mode_dec == JM_NONE || fork_mask == '0) begin
              state      <= JOIN;
              join_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt_next;
          if (join_cond) begin
            state         <= JOIN;
            join_valid    <= 1'b1;
            join_cycles   <= cnt_next;
            join_first_id <= hit_found ? hit_id : '0;
          end
`ifdef JOIN_TIMEOUT_EN
          else if (tmo) begin
            state         <= JOIN;
            join_valid    <= 1'b1;
            join_cycles   <= cnt_next;
            join_first_id <= '0;
            join_timeout  <= 1'b1;
          end
`endif
        end
        JOIN: begin
          if (join_ready) begin
            state      <= IDLE;
            join_valid <= 1'b0;
            fork_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          join_valid <= 1'b0;
          fork_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_tracker.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural join model.
module tb_fork_join_tracker;

  localparam int NJ = 4;
  localparam int CW = 16;
`ifdef JOIN_TIMEOUT_EN
  localparam int TO    = 50;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fork_valid = 1'b0;
  logic          join_ready = 1'b0;
  logic [NJ-1:0] fork_mask = '0;
  logic [NJ-1:0] done_valid = '0;
  logic [1:0]    join_mode = 2'b00;
  logic          fork_ready, join_valid, join_timeout, busy;
  logic [1:0]    join_first_id;
  logic [CW-1:0] join_cycles;
  logic [NJ-1:0] active_mask;

  always #5 clk = ~clk;

  fork_join_tracker #(.NUM_JOBS(NJ), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .fork_valid(fork_valid), .fork_ready(fork_ready), .fork_mask(fork_mask),
    .join_mode(join_mode), .done_valid(done_valid),
    .join_valid(join_valid), .join_ready(join_ready),
    .join_first_id(join_first_id), .join_cycles(join_cycles),
    .join_timeout(join_timeout), .active_mask(active_mask), .busy(busy)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting, 2 join pending; elapsed counts edges since accept.
  int            m_ph = 0, m_mode = 0, m_el = 0, m_id = 0, m_cyc = 0;
  bit            m_rdy = 0, m_jv = 0, m_to = 0;
  logic [NJ-1:0] m_act = '0, m_wait = '0;

  always @(posedge clk) begin : model
    bit            acc, fin;
    int            lo;
    logic [NJ-1:0] nact;
    if (rst) begin
      m_ph = 0; m_mode = 0; m_el = 0; m_id = 0; m_cyc = 0;
      m_rdy = 0; m_jv = 0; m_to = 0; m_act = '0; m_wait = '0;
    end else begin
      acc = fork_valid && m_rdy;
      lo  = -1;
      for (int j = 0; j < NJ; j++) begin
        nact[j] = m_act[j] && !done_valid[j];
        if (acc && fork_mask[j]) nact[j] = 1'b1;
        if (lo < 0 && done_valid[j] && m_act[j] && m_wait[j]) lo = j;
      end
      case (m_ph)
        0: if (acc) begin
          m_wait = fork_mask;
          m_mode = (join_mode == 2'd1) ? 1 : (join_mode == 2'd2) ? 2 : 0;
          m_el = 0; m_to = 0; m_id = 0; m_cyc = 0;
          m_ph = (m_mode == 2 || fork_mask == '0) ? 2 : 1;
        end
        1: begin
          m_el++;
          fin = (m_mode == 1) ? (lo >= 0) : ((m_wait & nact) == '0);
          if (fin) begin
            m_ph  = 2;
            m_id  = (lo < 0) ? 0 : lo;
            m_cyc = (m_el > 65535) ? 65535 : m_el;
          end else if (TO_EN && m_el == TO) begin
            m_ph = 2; m_to = 1; m_cyc = TO; m_id = 0;
          end
        end
        default: if (join_ready) m_ph = 0;
      endcase
      m_act = nact;
      m_rdy = (m_ph == 0);
      m_jv  = (m_ph == 2);
    end
  end

  always @(negedge clk) begin
    chk("fork_ready", fork_ready, m_rdy);
    chk("join_valid", join_valid, m_jv);
    chk("active_mask", active_mask, m_act);
    chk("busy", busy, (m_ph != 0) || (m_act != '0));
    if (m_jv) begin
      chk("join_first_id", join_first_id, m_id);
      chk("join_cycles", join_cycles, m_cyc);
      chk("join_timeout", join_timeout, m_to);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NJ-1:0] b);
    done_valid = b;
    @(negedge clk);
    done_valid = '0;
  endtask

  task automatic wait_rdy();
    int k = 0;
    while (!fork_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!fork_ready) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL wait_rdy: fork_ready still %0b after %0d cycles", fork_ready, k);
    end
  endtask

  task automatic fork_go(input logic [NJ-1:0] m, input logic [1:0] md);
    wait_rdy();
    fork_mask  = m;
    join_mode  = md;
    fork_valid = 1'b1;
    @(negedge clk);
    fork_valid = 1'b0;
    fork_mask  = '0;
  endtask

  task automatic handshake();
    join_ready = 1'b1;
    @(negedge clk);
    join_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_fork_ready", fork_ready, 0);
    chk("rst_join_valid", join_valid, 0);
    chk("rst_active", active_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycles", join_cycles, 0);
    chk("rst_timeout", join_timeout, 0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", fork_ready, 1);

    // ALL: last finisher at edge 30
    fork_go(4'b0011, 2'b00);
    idle(19); pulse(4'b0001);
    idle(9);  pulse(4'b0010);
    chk("t1_valid", join_valid, 1);
    chk("t1_cycles", join_cycles, 30);
    chk("t1_id", join_first_id, 1);
    chk("t1_active", active_mask, 0);
    handshake();
    chk("t1_ready", fork_ready, 1);

    // ANY: first finisher at edge 20, straggler clears silently
    fork_go(4'b0011, 2'b01);
    idle(19); pulse(4'b0001);
    chk("t2_valid", join_valid, 1);
    chk("t2_cycles", join_cycles, 20);
    chk("t2_id", join_first_id, 0);
    chk("t2_active", active_mask, 4'b0010);
    handshake();
    idle(8); pulse(4'b0010);
    chk("t2_active_end", active_mask, 0);
    chk("t2_no_rejoin", join_valid, 0);

    // NONE then refork while jobs still outstanding
    fork_go(4'b0011, 2'b10);
    chk("t3_valid", join_valid, 1);
    chk("t3_cycles", join_cycles, 0);
    chk("t3_active", active_mask, 4'b0011);
    handshake();
    chk("t3_ready", fork_ready, 1);
    fork_go(4'b0100, 2'b00);
    chk("t3_active2", active_mask, 4'b0111);
    idle(3); pulse(4'b0001); pulse(4'b0010);
    chk("t3_active3", active_mask, 4'b0100);
    chk("t3_wait", join_valid, 0);
    pulse(4'b0100);
    chk("t3_valid2", join_valid, 1);
    chk("t3_id2", join_first_id, 2);
    chk("t3_cycles2", join_cycles, 6);
    handshake();

    // Held join with backpressure; unrelated done still clears
    fork_go(4'b0100, 2'b10);
    handshake();
    fork_go(4'b0001, 2'b00);
    idle(2); pulse(4'b0001);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) pulse(4'b0100); else idle(1);
      chk("t4_valid", join_valid, 1);
      chk("t4_cycles", join_cycles, 3);
      chk("t4_ready", fork_ready, 0);
    end
    chk("t4_active", active_mask, 0);
    handshake();

    // ANY with simultaneous finishers, then reset mid-WAIT
    fork_go(4'b0110, 2'b01);
    idle(4); pulse(4'b0110);
    chk("t5_id", join_first_id, 1);
    chk("t5_cycles", join_cycles, 5);
    chk("t5_active", active_mask, 0);
    handshake();
    fork_go(4'b0011, 2'b00);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_ready", fork_ready, 0);
    chk("t5_rst_valid", join_valid, 0);
    chk("t5_rst_active", active_mask, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cycles", join_cycles, 0);
    chk("t5_rst_id", join_first_id, 0);
    @(negedge clk);
    chk("t5_ready_back", fork_ready, 1);

`ifdef JOIN_TIMEOUT_EN
    fork_go(4'b0001, 2'b00);
    idle(49);
    chk("t6_before", join_valid, 0);
    idle(1);
    chk("t6_valid", join_valid, 1);
    chk("t6_timeout", join_timeout, 1);
    chk("t6_cycles", join_cycles, 50);
    chk("t6_active", active_mask, 4'b0001);
    chk("t6_id", join_first_id, 0);
    handshake();
    pulse(4'b0001);
`endif

    for (int i = 0; i < 4000; i++) begin
      logic [NJ-1:0] d;
      for (int j = 0; j < NJ; j++) d[j] = ($urandom_range(0, 5) == 0);
      fork_valid = ($urandom_range(0, 2) == 0);
      fork_mask  = NJ'($urandom);
      join_mode  = 2'($urandom);
      done_valid = d;
      join_ready = ($urandom_range(0, 1) == 1);
      rst        = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0; fork_valid = 1'b0; done_valid = '0; join_ready = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fork_join_tracker.md
Name: fork_join_tracker

Overview:
Hardware join unit that pairs with a job launcher. It accepts a fork request, given as a bitmask of parallel jobs, and tracks each job's completion pulse. It then reports the join event under ALL, ANY or NONE semantics, along with the elapsed cycle count. It sits between a job dispatcher and the control sequencer that must wait on spawned work.

Parameters:
NUM_JOBS, 4, number of trackable parallel jobs (≥2)
CNT_W, 16, width of elapsed-cycle counter
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with JOIN_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
fork_valid  in  1  fork request valid
fork_ready  out  1  tracker can accept fork
fork_mask  in  NUM_JOBS  jobs launched by this fork
join_mode  in  2  00 ALL, 01 ANY, 10 NONE, 11 treated as ALL
done_valid  in  NUM_JOBS  per-job one-cycle completion pulses
join_valid  out  1  join event available
join_ready  in  1  consumer accepts join event
join_first_id  out  $clog2(NUM_JOBS)  triggering job index
join_cycles  out  CNT_W  cycles from fork accept to join condition
join_timeout  out  1  join caused by watchdog
active_mask  out  NUM_JOBS  currently outstanding jobs
busy  out  1  state != IDLE or active_mask != 0

Behaviour:
- Reset: state IDLE. All outputs 0: fork_ready, join_valid, join_first_id, join_cycles, join_timeout, active_mask, busy. fork_ready goes to 1 on the first cycle after rst deasserts. A reset mid-operation drops any pending join and clears all tracking.
- FSM states: IDLE, WAIT, JOIN.
- fork_ready = (state == IDLE).
- A fork is accepted at an edge where fork_valid && fork_ready.
- On accept:
  - latch wait_set = fork_mask and mode.
  - active_mask |= fork_mask.
  - clear counter to 0.
- Mode NONE, or fork_mask == 0 → go to JOIN. join_valid rises the cycle after accept, with join_cycles=0 and join_first_id=0.
- Otherwise → go to WAIT. The counter increments every WAIT cycle and saturates at all-ones.
- done_valid bit i clears active_mask[i] only when that bit is set. Pulses for inactive jobs are ignored. This applies in every state, including after a NONE join has been consumed.
- Same-edge done and fork on the same bit: done clears the old instance and the fork sets the bit again; the result is active.
- ALL join condition: (wait_set & active_mask_next) == 0.
- ANY join condition: at least one done pulse hits an active bit of wait_set.
- Join condition seen at edge k after accept → go to JOIN. Then:
  - join_cycles = k.
  - join_first_id = lowest index among wait_set bits pulsing at that edge (ALL: the last finisher).
- JOIN: join_valid = 1 and outputs are held stable until join_valid && join_ready, then return to IDLE.
- ANY: remaining jobs stay in active_mask. They clear silently and generate no second join.

Optional Feature:
Macro JOIN_TIMEOUT_EN.
- Defined: if WAIT persists TIMEOUT_CYC cycles, go to JOIN with join_timeout=1, join_cycles=TIMEOUT_CYC and join_first_id=0. Outstanding bits remain in active_mask.
- Undefined: no watchdog logic. join_timeout is tied 0, and WAIT lasts indefinitely.

Decomposition:
Package fork_join_pkg holds:
- join_mode_e enum (JM_ALL, JM_ANY, JM_NONE).
- state_e enum (IDLE, WAIT, JOIN).
- job-ID width localparam helper.
One sub-module, fj_lowest_bit_enc: a parameterised lowest-set-bit priority encoder that returns the index and a found flag. It is used for join_first_id.

Test Plan:
1. ALL, mask 4'b0011; done[0] at +20, done[1] at +30 → join_valid after edge +30, join_cycles=30, join_first_id=1, active_mask=0000.
2. ANY, mask 4'b0011; done[0] at +20, done[1] at +30 → join at +20 with id=0, cycles=20, active_mask=0010. done[1] then clears it to 0000 with no second join.
3. NONE, mask 4'b0011 → join_valid the cycle after accept, cycles=0. Refork mask 0100 is accepted while active_mask=0011. Later done pulses clear bits correctly.
4. ALL, mask 0001, join_ready held 0 for 5 cycles → join_valid and outputs stable, fork_ready=0. A done[2] pulse arriving meanwhile still clears active_mask[2].
5. ANY, mask 0110, done[1] and done[2] on the same edge → join_first_id=1. Then assert rst mid-WAIT in a second run → all outputs 0 on the next cycle.
6. JOIN_TIMEOUT_EN, TIMEOUT_CYC=50, ALL mask 0001, no done → join at +50 with join_timeout=1, active_mask=0001.
